// File: rtl/pushbutton_debouncer_bank_if.sv
// Button bank bundle: raw pb_in towards the conditioner and the per-channel clean level and strobes back.
// The slave modport is the conditioner side; master is the consumer/stimulus side.
interface pushbutton_debouncer_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] pb_in;
    logic [CHANNELS-1:0] pb_state;
    logic [CHANNELS-1:0] pb_down;
    logic [CHANNELS-1:0] pb_up;
    logic [CHANNELS-1:0] pb_long;
    logic [CHANNELS-1:0] pb_repeat;

    modport master (
        output pb_in,
        input  pb_state,
        input  pb_down,
        input  pb_up,
        input  pb_long,
        input  pb_repeat
    );

    modport slave (
        input  pb_in,
        output pb_state,
        output pb_down,
        output pb_up,
        output pb_long,
        output pb_repeat
    );
endinterface

// File: rtl/pushbutton_debouncer_bank.sv
// Per-channel 2-flop sync, counter debounce, press/release strobes and IDLE/HOLD/REPEAT long-press FSM.
// Press/release latency 2^DEBOUNCE_W+2 edges; all outputs registered; no backpressure (strobes are fire-and-forget).
module pushbutton_debouncer_bank #(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE_W    = 16,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int HOLD_W        = 25,
    parameter int HOLD_CYCLES   = 27000000,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_CYCLES = 5400000
) (
    input  logic                          clock27MHz,
    input  logic                          reset,
    pushbutton_debouncer_bank_if.slave    pb
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [CHANNELS-1:0] pb_norm;
    logic [CHANNELS-1:0] state_w;
    logic [CHANNELS-1:0] down_w;
    logic [CHANNELS-1:0] up_w;
    logic [CHANNELS-1:0] long_w;
    logic [CHANNELS-1:0] repeat_w;

    assign pb_norm = ACTIVE_LOW ? ~pb.pb_in : pb.pb_in;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic                  sync0_q;
        logic                  sync1_q;
        logic [DEBOUNCE_W-1:0] db_cnt_q;
        logic [DEBOUNCE_W-1:0] db_cnt_d;
        logic                  state_q;
        logic                  state_d;
        logic                  down_q;
        logic                  up_q;
        logic                  long_q;
        logic                  long_d;
        logic                  repeat_q;
        logic                  repeat_d;
        logic [1:0]            fsm_q;
        logic [1:0]            fsm_d;
        logic [HOLD_W-1:0]     hold_cnt_q;
        logic [HOLD_W-1:0]     hold_cnt_d;
        logic                  mismatch;
        logic                  toggle;
        logic                  rise;
        logic                  fall;

        // Counter wraps to 0 on its own on the accepting edge.
        assign mismatch = sync1_q != state_q;
        assign toggle   = mismatch && (&db_cnt_q);
        assign rise     = toggle && !state_q;
        assign fall     = toggle && state_q;
        assign db_cnt_d = mismatch ? db_cnt_q + 1'b1 : '0;
        assign state_d  = state_q ^ toggle;

        always_comb begin
            fsm_d      = fsm_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
            if (fall) begin
                // Release wins over a coinciding terminal count.
                fsm_d      = ST_IDLE;
                hold_cnt_d = '0;
            end else begin
                case (fsm_q)
                    ST_IDLE: begin
                        hold_cnt_d = '0;
                        if (rise) begin
                            fsm_d = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            long_d     = 1'b1;
                            hold_cnt_d = '0;
                            fsm_d      = ST_REPEAT;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (REPEAT_EN) begin
                            if (hold_cnt_q == REPEAT_LAST) begin
                                repeat_d   = 1'b1;
                                hold_cnt_d = '0;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 1'b1;
                            end
                        end else begin
                            hold_cnt_d = '0;
                        end
                    end
                    default: begin
                        fsm_d      = ST_IDLE;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clock27MHz or posedge reset) begin
            if (reset) begin
                sync0_q    <= 1'b0;
                sync1_q    <= 1'b0;
                db_cnt_q   <= '0;
                state_q    <= 1'b0;
                down_q     <= 1'b0;
                up_q       <= 1'b0;
                long_q     <= 1'b0;
                repeat_q   <= 1'b0;
                fsm_q      <= ST_IDLE;
                hold_cnt_q <= '0;
            end else begin
                sync0_q    <= pb_norm[ch];
                sync1_q    <= sync0_q;
                db_cnt_q   <= db_cnt_d;
                state_q    <= state_d;
                down_q     <= rise;
                up_q       <= fall;
                long_q     <= long_d;
                repeat_q   <= repeat_d;
                fsm_q      <= fsm_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        assign state_w[ch]  = state_q;
        assign down_w[ch]   = down_q;
        assign up_w[ch]     = up_q;
        assign long_w[ch]   = long_q;
        assign repeat_w[ch] = repeat_q;
    end

    assign pb.pb_state  = state_w;
    assign pb.pb_down   = down_w;
    assign pb.pb_up     = up_w;
    assign pb.pb_long   = long_w;
    assign pb.pb_repeat = repeat_w;

endmodule

// File: tb/tb_pushbutton_debouncer_bank.sv
// Directed stimulus on two banks (repeat enabled / disabled); expected strobe events are queued with their
// cycle stamps and a negedge monitor pops and compares each time a bank shows a strobe.
module tb_pushbutton_debouncer_bank;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  st;
        logic [3:0]  dn;
        logic [3:0]  up;
        logic [3:0]  lg;
        logic [3:0]  rp;
    } evt_t;

    evt_t exp_a[$];
    evt_t exp_b[$];

    pushbutton_debouncer_bank_if #(.CHANNELS(CH)) ifa ();
    pushbutton_debouncer_bank_if #(.CHANNELS(CH)) ifb ();

    pushbutton_debouncer_bank #(
        .CHANNELS(CH), .DEBOUNCE_W(4), .ACTIVE_LOW(1'b1), .HOLD_W(8),
        .HOLD_CYCLES(40), .REPEAT_EN(1'b1), .REPEAT_CYCLES(10)
    ) dut_a (
        .clock27MHz(clk),
        .reset(rst),
        .pb(ifa)
    );

    pushbutton_debouncer_bank #(
        .CHANNELS(CH), .DEBOUNCE_W(4), .ACTIVE_LOW(1'b1), .HOLD_W(8),
        .HOLD_CYCLES(40), .REPEAT_EN(1'b0), .REPEAT_CYCLES(10)
    ) dut_b (
        .clock27MHz(clk),
        .reset(rst),
        .pb(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int dut, input int at, input logic [3:0] st, input logic [3:0] dn,
                             input logic [3:0] up, input logic [3:0] lg, input logic [3:0] rp);
        evt_t e;
        e = {32'(at), st, dn, up, lg, rp};
        if (dut == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
    endtask

    task automatic score(input int dut, input evt_t act);
        evt_t e;
        checks++;
        if ((dut == 0 && exp_a.size() == 0) || (dut == 1 && exp_b.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_strobe dut%0d: got cyc=%0d st=%b dn=%b up=%b lg=%b rp=%b, required no strobe",
                     dut, act.cyc, act.st, act.dn, act.up, act.lg, act.rp);
            return;
        end
        if (dut == 0) e = exp_a.pop_front();
        else          e = exp_b.pop_front();
        if (act !== e) begin
            failures++;
            $display("FAIL strobe_event dut%0d: got cyc=%0d st=%b dn=%b up=%b lg=%b rp=%b, required cyc=%0d st=%b dn=%b up=%b lg=%b rp=%b",
                     dut, act.cyc, act.st, act.dn, act.up, act.lg, act.rp, e.cyc, e.st, e.dn, e.up, e.lg, e.rp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((ifa.pb_down | ifa.pb_up | ifa.pb_long | ifa.pb_repeat) != 4'b0)
                score(0, {32'(cyc), ifa.pb_state, ifa.pb_down, ifa.pb_up, ifa.pb_long, ifa.pb_repeat});
            if ((ifb.pb_down | ifb.pb_up | ifb.pb_long | ifb.pb_repeat) != 4'b0)
                score(1, {32'(cyc), ifb.pb_state, ifb.pb_down, ifb.pb_up, ifb.pb_long, ifb.pb_repeat});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        ifa.pb_in = 4'hF;
        ifb.pb_in = 4'hF;
        rst = 1'b1;
        idle(3);
        chk("reset_outs_a", 32'({ifa.pb_state, ifa.pb_down, ifa.pb_up, ifa.pb_long, ifa.pb_repeat}), 32'h0);
        chk("reset_outs_b", 32'({ifb.pb_state, ifb.pb_down, ifb.pb_up, ifb.pb_long, ifb.pb_repeat}), 32'h0);
        rst = 1'b0;

        // All channels pressed, then an asynchronous reset while held, then re-detection.
        idle(1);
        c = cyc;
        ifa.pb_in = 4'h0;
        expect_ev(0, c + 18, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        idle(25);
        chk("state_all_pressed", 32'(ifa.pb_state), 32'hF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outs_a", 32'({ifa.pb_state, ifa.pb_down, ifa.pb_up, ifa.pb_long, ifa.pb_repeat}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        c = cyc;
        expect_ev(0, c + 18, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        idle(25);
        ifa.pb_in = 4'hF;
        expect_ev(0, c + 43, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
        idle(30);

        // Clean ch0 press held 100 cycles; the repeat due on the release edge is suppressed.
        c = cyc;
        ifa.pb_in[0] = 1'b0;
        expect_ev(0, c + 18, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        expect_ev(0, c + 58, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        for (int i = 0; i < 5; i++)
            expect_ev(0, c + 68 + 10 * i, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
        expect_ev(0, c + 118, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        idle(100);
        ifa.pb_in[0] = 1'b1;
        idle(40);

        // ch1 bounce every 5 cycles, settle low, release; then a 15-cycle glitch.
        c = cyc;
        for (int i = 0; i < 12; i++) begin
            ifa.pb_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            idle(5);
        end
        ifa.pb_in[1] = 1'b0;
        expect_ev(0, c + 78, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
        idle(28);
        ifa.pb_in[1] = 1'b1;
        expect_ev(0, c + 106, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
        idle(30);
        ifa.pb_in[1] = 1'b0;
        idle(15);
        ifa.pb_in[1] = 1'b1;
        idle(30);
        chk("glitch_state", 32'(ifa.pb_state), 32'h0);

        // ch2 long press with repeats up to +100, released before the +110 repeat.
        c = cyc;
        ifa.pb_in[2] = 1'b0;
        expect_ev(0, c + 18, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        expect_ev(0, c + 58, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0);
        for (int i = 0; i < 6; i++)
            expect_ev(0, c + 68 + 10 * i, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4);
        expect_ev(0, c + 121, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
        idle(103);
        ifa.pb_in[2] = 1'b1;
        idle(40);

        // ch3 released so that pb_state falls exactly at +40: no long strobe.
        c = cyc;
        ifa.pb_in[3] = 1'b0;
        expect_ev(0, c + 18, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
        expect_ev(0, c + 58, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0);
        idle(40);
        ifa.pb_in[3] = 1'b1;
        idle(40);

        // Repeat-disabled bank: long strobe only, never a repeat.
        c = cyc;
        ifb.pb_in[0] = 1'b0;
        expect_ev(1, c + 18, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        expect_ev(1, c + 58, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        expect_ev(1, c + 118, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        idle(100);
        ifb.pb_in[0] = 1'b1;
        idle(40);

        // ch0 and ch3 together, reset while in REPEAT.
        c = cyc;
        ifa.pb_in = 4'b0110;
        expect_ev(0, c + 18, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0);
        expect_ev(0, c + 58, 4'h9, 4'h0, 4'h0, 4'h9, 4'h0);
        expect_ev(0, c + 68, 4'h9, 4'h0, 4'h0, 4'h0, 4'h9);
        idle(72);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("repeat_reset_outs_a", 32'({ifa.pb_state, ifa.pb_down, ifa.pb_up, ifa.pb_long, ifa.pb_repeat}), 32'h0);
        @(negedge clk);
        ifa.pb_in = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        idle(30);

        // Fresh press after reset: long lands exactly at +40, so the hold counter restarted from zero.
        c = cyc;
        ifa.pb_in[0] = 1'b0;
        expect_ev(0, c + 18, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        expect_ev(0, c + 58, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        expect_ev(0, c + 63, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        idle(45);
        ifa.pb_in[0] = 1'b1;
        idle(40);

        chk("pending_events_a", 32'(exp_a.size()), 32'h0);
        chk("pending_events_b", 32'(exp_b.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pushbutton_debouncer_bank.md
# pushbutton_debouncer_bank

Multi-channel push-button conditioner: synchronises, debounces and edge-detects `CHANNELS` independent glitchy button inputs. It also generates long-press and auto-repeat pulses for each channel. It sits between the board push-buttons and the processor control/stepping logic, replacing per-button single-channel debouncers with one parametrised block. Each channel produces a clean level plus one-cycle press, release, long-press and repeat strobes, all synchronous to `clock27MHz`.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `DEBOUNCE_W`, 16: debounce counter width; a change is accepted after 2^DEBOUNCE_W consecutive disagreeing cycles (~2.4 ms at 27 MHz).
- `ACTIVE_LOW`, 1: 1 = `pb_in` low means pressed; 0 = high means pressed.
- `HOLD_W`, 25: width of per-channel hold counter.
- `HOLD_CYCLES`, 27000000: cycles held (after accepted press) before `pb_long`; 1 ≤ HOLD_CYCLES < 2^HOLD_W.
- `REPEAT_EN`, 1: 1 = emit `pb_repeat` after long press; 0 = never.
- `REPEAT_CYCLES`, 5400000: auto-repeat period; 1 ≤ REPEAT_CYCLES < 2^HOLD_W.

Ports:
- `clock27MHz` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `pb_in` in CHANNELS: raw asynchronous button inputs.
- `pb_state` out CHANNELS: debounced level, 1 = pressed.
- `pb_down` out CHANNELS: one-cycle strobe on accepted press.
- `pb_up` out CHANNELS: one-cycle strobe on accepted release.
- `pb_long` out CHANNELS: one-cycle strobe when held HOLD_CYCLES.
- `pb_repeat` out CHANNELS: one-cycle strobe every REPEAT_CYCLES after `pb_long` while held.

## Operation
- Each channel is fully independent and replicated; there is no cross-channel interaction. Simultaneous events on different channels all fire in the same cycle.
- Input conditioning: the input is normalised to active-high (inverted when ACTIVE_LOW=1), then passed through 2 flops: `sync0` then `sync1`.
- Debounce counter (DEBOUNCE_W bits):
  - If `sync1 == pb_state`, the counter clears to 0.
  - Otherwise it increments (natural wrap).
  - On the edge where the counter is all-ones and a mismatch is present, `pb_state` toggles and the counter wraps to 0.
- Strobes: `pb_down` and `pb_up` are registered alongside the toggle.
  - `pb_down` = 1 for exactly one cycle when `pb_state` goes 0→1.
  - `pb_up` = 1 for exactly one cycle when `pb_state` goes 1→0.
- Hold FSM per channel, states IDLE, HOLD, REPEAT:
  - IDLE: hold counter = 0. Leaves to HOLD on the `pb_state` 0→1 edge.
  - HOLD: counter increments each cycle while `pb_state` = 1. When counter == HOLD_CYCLES−1, it pulses `pb_long`, clears the counter and goes to REPEAT.
  - REPEAT: counter increments. When counter == REPEAT_CYCLES−1 and REPEAT_EN=1, it pulses `pb_repeat` and clears the counter. With REPEAT_EN=0 the counter is frozen at 0 and the FSM stays in REPEAT.
  - Any state: the `pb_state` 1→0 edge returns to IDLE and clears the counter in the same cycle as `pb_up`. A pending `pb_long`/`pb_repeat` whose terminal count coincides with release is suppressed.
- Glitches shorter than 2^DEBOUNCE_W cycles never change `pb_state`. Bounce resets the counter on every return to the agreeing level.

## Timing
- Reset values (all channels): `pb_state`=0, `pb_down`=0, `pb_up`=0, `pb_long`=0, `pb_repeat`=0. Sync flops reset to "released" (0 after normalisation), counters reset to 0, FSM resets to IDLE.
- Press latency: the input is pressed and stable from edge k, the first edge that samples it. `pb_state` and `pb_down` assert after edge k+2^DEBOUNCE_W+1, which is 2^DEBOUNCE_W+2 edges in total. Release latency is identical, with `pb_up`.
- `pb_long` asserts after edge E+HOLD_CYCLES, where E is the edge that set `pb_state`.
- The first `pb_repeat` asserts REPEAT_CYCLES edges after `pb_long`, then every REPEAT_CYCLES edges.
- All strobes are high for exactly one cycle, and at most one strobe per channel is high in any cycle.
- Reset mid-operation clears outputs asynchronously. If a button is still held at reset release, it is re-detected after the full press latency, producing a fresh `pb_down`.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_W=4, HOLD_CYCLES=40, REPEAT_CYCLES=10, ACTIVE_LOW=1.

- Reset check: assert `reset` mid-cycle with all inputs low (pressed) -> all outputs 0 immediately. After release, `pb_state[*]`=1 and `pb_down[*]` pulses exactly 18 edges later.
- Clean press/release on ch0: drive `pb_in[0]` low -> `pb_down[0]` one cycle at edge 18. Drive it high 100 cycles later -> `pb_up[0]` one cycle at edge 18 after release. Other channels stay 0.
- Bounce: toggle `pb_in[1]` every 5 cycles for 60 cycles, then hold low -> exactly one `pb_down[1]`, 18 edges after the final transition. A 15-cycle low glitch -> no output change.
- Long press and repeat on ch2: hold for 100 cycles after `pb_state` rises -> `pb_long[2]` at +40, then `pb_repeat[2]` at +50, +60, ... +100. Release -> `pb_up[2]`, and no further repeats.
- Release at terminal count: release timed so that `pb_state` falls on the edge +40 -> `pb_up` only, no `pb_long`. Same check with REPEAT_EN=0 -> `pb_long` only, never `pb_repeat`.
- Simultaneous: press ch0 and ch3 on the same edge -> both `pb_down` fire in the same cycle. Reset asserted during REPEAT -> all strobes and counters clear, and the FSM returns to IDLE.
